// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_pkg
//  Description : Phase codes, lamp encodings and requester type shared by the
//                intersection light arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package traffic_pkg;

    typedef logic [2:0] phase_t;
    typedef logic [2:0] lamp_t;

    localparam phase_t HG = 3'd0;
    localparam phase_t HY = 3'd1;
    localparam phase_t AR = 3'd2;
    localparam phase_t FG = 3'd3;
    localparam phase_t FY = 3'd4;
    localparam phase_t PW = 3'd5;

    localparam lamp_t RED = 3'b100;
    localparam lamp_t YEL = 3'b010;
    localparam lamp_t GRN = 3'b001;

    typedef enum logic {
        REQ_FARM = 1'b0,
        REQ_PED  = 1'b1
    } req_t;

    // Round-robin partner of the last served requester.
    function automatic req_t other_req(input req_t r);
        if (r == REQ_FARM) begin
            return REQ_PED;
        end
        return REQ_FARM;
    endfunction

endpackage
`default_nettype wire

// File: rtl/light_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : light_arbiter_if
//  Description : Request inputs and lamp outputs of the intersection arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface light_arbiter_if;
    import traffic_pkg::*;

    logic   c;
    logic   ped_req;
    logic   emg;
    lamp_t  HL;
    lamp_t  FL;
    logic   walk;
    logic   ped_ack;
    phase_t phase;

    modport master (
        output c, ped_req, emg,
        input  HL, FL, walk, ped_ack, phase
    );

    modport slave (
        input  c, ped_req, emg,
        output HL, FL, walk, ped_ack, phase
    );
endinterface
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : phase_timer
//  Description : Loadable dwell down-counter; parks at zero, can be frozen.
//  Revision    : 1.0  initial release
// ============================================================================
module phase_timer #(
    parameter int CW      = 8,
    parameter int RST_VAL = 24
) (
    input  wire          clk,
    input  wire          rst,
    input  wire          load,
    input  wire [CW-1:0] load_val,
    input  wire          hold,
    output logic         zero
);

    logic [CW-1:0] r_cnt;

    // Load wins over hold so a phase change always starts a fresh dwell.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= CW'(RST_VAL);
        end else if (load) begin
            r_cnt <= load_val;
        end else if (!hold && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/light_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : light_arbiter
//  Description : Intersection phase scheduler arbitrating highway, farm road,
//                pedestrian and emergency pre-empt; drives the lamps.
//  Revision    : 1.0  initial release
// ============================================================================
module light_arbiter
    import traffic_pkg::*;
#(
    parameter int CW     = 8,
    parameter int T_HG   = 25,
    parameter int T_YEL  = 4,
    parameter int T_FG   = 15,
    parameter int T_WALK = 10,
    parameter int T_AR   = 2
) (
    input  wire             clk,
    input  wire             rst,
    light_arbiter_if.slave  bus
);

    phase_t        r_state;
    phase_t        w_next;
    req_t          r_last;
    req_t          r_grant;
    req_t          w_grant;
    logic          r_ret;
    logic          w_ret;
    logic          r_pend;
    logic          r_ack;
    logic          w_zero;
    logic          w_load;
    logic          w_hold;
    logic [CW-1:0] w_load_val;
    logic          w_pw_entry;
    logic          w_fg_entry;

    function automatic logic [CW-1:0] dwell(input phase_t s);
        case (s)
            HY, FY:  return CW'(T_YEL - 1);
            AR:      return CW'(T_AR - 1);
            FG:      return CW'(T_FG - 1);
            PW:      return CW'(T_WALK - 1);
            default: return CW'(T_HG - 1);
        endcase
    endfunction

    phase_timer #(
        .CW      (CW),
        .RST_VAL (T_HG - 1)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .hold     (w_hold),
        .zero     (w_zero)
    );

    assign w_load     = (w_next != r_state);
    assign w_load_val = dwell(w_next);
    assign w_hold     = (r_state == HG) && bus.emg;
    assign w_pw_entry = (w_next == PW) && (r_state != PW);
    assign w_fg_entry = (w_next == FG) && (r_state != FG);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= HG;
            r_ret   <= 1'b0;
            r_grant <= REQ_FARM;
            r_last  <= REQ_PED;
            r_pend  <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ret   <= w_ret;
            r_grant <= w_grant;
            r_ack   <= w_pw_entry;
            // Entering walk absorbs a press in that same cycle.
            if (w_pw_entry) begin
                r_pend <= 1'b0;
                r_last <= REQ_PED;
            end else begin
                if ((r_state != PW) && bus.ped_req) begin
                    r_pend <= 1'b1;
                end
                if (w_fg_entry) begin
                    r_last <= REQ_FARM;
                end
            end
        end
    end

    always_comb begin
        w_next  = r_state;
        w_grant = r_grant;
        w_ret   = r_ret;
        case (r_state)
            HG: begin
                if (w_zero && (bus.c || r_pend) && !bus.emg) begin
                    w_next = HY;
                    if (bus.c && r_pend) begin
                        w_grant = other_req(r_last);
                    end else if (bus.c) begin
                        w_grant = REQ_FARM;
                    end else begin
                        w_grant = REQ_PED;
                    end
                end
            end
            HY: begin
                if (w_zero) begin
                    w_next = AR;
                    w_ret  = 1'b0;
                end
            end
            AR: begin
                // Emergency on the way out abandons the grant; requests stay pending.
                if (w_zero) begin
                    if (r_ret || bus.emg) begin
                        w_next = HG;
                    end else if (r_grant == REQ_PED) begin
                        w_next = PW;
                    end else begin
                        w_next = FG;
                    end
                end
            end
            FG: begin
                if (w_zero || !bus.c || bus.emg) begin
                    w_next = FY;
                end
            end
            FY: begin
                if (w_zero) begin
                    w_next = AR;
                    w_ret  = 1'b1;
                end
            end
            PW: begin
                if (w_zero || bus.emg) begin
                    w_next = AR;
                    w_ret  = 1'b1;
                end
            end
            default: w_next = HG;
        endcase
    end

    always_comb begin
        bus.HL      = RED;
        bus.FL      = RED;
        bus.walk    = 1'b0;
        bus.ped_ack = r_ack;
        bus.phase   = r_state;
        case (r_state)
            HG:      bus.HL   = GRN;
            HY:      bus.HL   = YEL;
            FG:      bus.FL   = GRN;
            FY:      bus.FL   = YEL;
            PW:      bus.walk = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/light_arbiter.md
# light_arbiter

- Phase scheduler and arbiter for the intersection's single green-time resource.
- Three requesters compete for it: the highway (default holder), the farm-road car sensor and a latched pedestrian button. An emergency input pre-empts all of them.
- Runs on the divided 1-tick clock and drives HL/FL directly.
- Contains its own programmable dwell timer, so no external timer handshake is needed.

## Interface
Parameters:
- CW, 8: dwell counter width.
- T_HG, 25: minimum highway-green dwell, in ticks.
- T_YEL, 4: yellow dwell, highway and farm.
- T_FG, 15: maximum farm-green dwell.
- T_WALK, 10: pedestrian walk dwell.
- T_AR, 2: all-red clearance dwell.
- Every T_* is in 1..2^CW.

Ports:
- clk  in  1: divided slow clock; single clock domain.
- rst  in  1: reset, asynchronous, active-low.
- c  in  1: farm-road car sensor, level.
- ped_req  in  1: pedestrian button; any high cycle sets a pending bit.
- emg  in  1: emergency pre-empt, level.
- HL  out  3: highway light, one-hot {red, yellow, green}.
- FL  out  3: farm light, same encoding.
- walk  out  1: pedestrian walk lamp.
- ped_ack  out  1: one-cycle pulse on the first cycle of WALK.
- phase  out  3: current state code, for debug.

## Operation
States and lamp decode:
- HG: HL green, FL red.
- HY: HL yellow, FL red.
- AR: all red.
- FG: HL red, FL green.
- FY: HL red, FL yellow.
- PW: all red, walk=1.

Registers:
- State.
- Down-counter cnt.
- ped_pend: pending pedestrian request.
- last: last served requester, 0=farm, 1=ped.
- ret: AR returns to HG.
- grant: next non-highway phase.

Each state entry loads cnt with T_state-1. A state exits only when cnt==0, except for the early exits listed below.

Transitions:
- HG: when cnt==0 and (c or ped_pend) and !emg, go to HY.
  - If both requests are pending, grant goes to the one ≠ last (round-robin). Otherwise grant goes to whichever is pending.
  - Otherwise HG holds with cnt at 0.
- HY: go to AR with ret=0.
- AR: if ret=1, go to HG. Else go to FG if grant=farm, or PW if grant=ped.
  - If emg is high when AR with ret=0 would exit, go to HG instead. The request stays pending.
- FG: go to FY on cnt==0, or on the first cycle with c==0 (gap-out), or immediately on emg. On entry, last is set to farm.
- FY: go to AR with ret=1.
- PW: go to AR with ret=1 on cnt==0, or immediately on emg. On entry, ped_pend is cleared and last is set to ped.
- While emg is high in HG, cnt freezes and no exit occurs.

Pedestrian request handling:
- A ped_req in the same cycle as PW entry is absorbed.
- A ped_req during PW is ignored.
- A ped_req in any other state sets ped_pend.

c is not latched: a car that leaves before the HG exit cancels its own request.

## Timing
Reset (rst low) forces, asynchronously:
- State HG, cnt=T_HG-1.
- ped_pend=0, last=ped, ret=0, grant=farm.
- HL=001, FL=100, walk=0, ped_ack=0, phase=HG.

Output timing:
- Outputs are Moore decodes of registered state and change on the same edge as the state.
- ped_ack is high for exactly one cycle, the PW entry cycle.

Dwell lengths:
- A state entered at edge k with no early exit occupies exactly T_state cycles.
- From reset with c held high:
  - HG covers cycles 0–24.
  - HY covers cycles 25–28.
  - AR covers cycles 29–30.
  - FG starts at cycle 31.

Early-exit timing:
- Gap-out and emg exits take effect at the next edge after the condition is sampled.

Reset mid-phase:
- Reset during any phase returns to the full reset state.
- Pending requests are lost.

## Structure
- Shared package traffic_pkg holds:
  - State encodings: HG=0, HY=1, AR=2, FG=3, FY=4, PW=5.
  - Lamp constants: RED=3'b100, YEL=3'b010, GRN=3'b001.
- Sub-module phase_timer holds the dwell counter:
  - Inputs: load, load_val[CW-1:0], hold.
  - Output: zero.
  - Reset value T_HG-1.
- light_arbiter holds the FSM, the arbitration and the lamp decode.

## Test plan
1. Reset then idle for 100 cycles → HL=001, FL=100, walk=0 throughout; phase stays HG.
2. c high from reset → HY at cycle 25, AR at 29, FG at 31; FG runs 15 cycles (until FY at 46); AR at 50 with ret=1; HG at 52.
3. ped_req one-cycle pulse at cycle 3, c low → PW entered at cycle 31 with ped_ack pulse; walk=1 for 10 cycles; ped_pend=0 afterwards.
4. c and ped_req both pending at the HG exit after reset (last=ped) → farm served first; pedestrian served in the next cycle round, after the next full T_HG.
5. c high, then dropped on cycle 3 of FG → FY on the next edge (gap-out), FY lasts 4 cycles.
6. emg raised mid-PW → walk drops at the next edge and AR begins; emg held → HG held with cnt frozen; emg released → HG exits once cnt==0 and a request is pending.
